// File: rtl/stv_cart_mem_arbiter.sv
// stv_cart_mem_arbiter: shares the ST-V cartridge ROM read port among the A-bus,
// 315-5838 and 315-5881 requesters; one read in flight, timeout abort, sticky ERR.
`default_nettype none

module stv_cart_mem_arbiter #(
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        res_n_i,
    input  logic [2:0]  req_i,
    input  logic [25:1] a0_i,
    input  logic [25:1] a1_i,
    input  logic [25:1] a2_i,
    output logic [2:0]  ack_o,
    output logic [2:0]  gnt_o,
    output logic [15:0] rd_data_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [25:1] mem_a_o,
    output logic        mem_rd_o,
    input  logic [15:0] mem_di_i,
    input  logic        mem_rdy_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  ack_q, ack_d;
    logic        mem_rd_q, mem_rd_d;
    logic [25:1] mem_a_q, mem_a_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  win_idx;
    logic        win_vld;
    logic [25:1] win_addr;

    // Rotating search from ptr_q; the pointer never leaves 0 in fixed-priority mode,
    // so the same search degenerates to lowest-index-wins.
    always_comb begin
        logic [2:0] cand;
        win_idx = 2'd0;
        win_vld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (req_i[cand[1:0]]) begin
                win_idx = cand[1:0];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        case (win_idx)
            2'd1:    win_addr = a1_i;
            2'd2:    win_addr = a2_i;
            default: win_addr = a0_i;
        endcase
    end

    // State register and all output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            mem_rd_q  <= 1'b0;
            mem_a_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            mem_rd_q  <= mem_rd_d;
            mem_a_q   <= mem_a_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rdy_i || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!res_n_i) begin
            state_d = S_IDLE;
        end
    end

    // Output / datapath next values
    always_comb begin
        gnt_d     = gnt_q;
        ack_d     = '0;
        mem_rd_d  = mem_rd_q;
        mem_a_d   = mem_a_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    gnt_d    = 3'b001 << win_idx;
                    mem_a_d  = win_addr;
                    mem_rd_d = 1'b1;
                    cnt_d    = '0;
                    if (RR_MODE != 0) begin
                        ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rdy_i) begin
                    mem_rd_d  = 1'b0;
                    rd_data_d = mem_di_i;
                    ack_d     = gnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    mem_rd_d  = 1'b0;
                    rd_data_d = 16'hFFFF;
                    err_d     = 1'b1;
                    ack_d     = gnt_q;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
        // Console reset drops any transfer silently; address and data are kept.
        if (!res_n_i) begin
            gnt_d    = '0;
            ack_d    = '0;
            mem_rd_d = 1'b0;
            err_d    = 1'b0;
            ptr_d    = '0;
            cnt_d    = '0;
        end
    end

    assign ack_o     = ack_q;
    assign gnt_o     = gnt_q;
    assign rd_data_o = rd_data_q;
    assign err_o     = err_q;
    assign busy_o    = (state_q != S_IDLE);
    assign mem_a_o   = mem_a_q;
    assign mem_rd_o  = mem_rd_q;

endmodule

`default_nettype wire

// File: tb/tb_stv_cart_mem_arbiter.sv
// tb_stv_cart_mem_arbiter: directed and randomized transactions on two arbiter
// instances (round-robin/TIMEOUT=8 and fixed-priority/TIMEOUT=4) against a transaction model.
`default_nettype none

module tb_stv_cart_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_n   [2];
    logic [2:0]  req     [2];
    logic [25:1] a       [2][3];
    logic [15:0] mem_di  [2];
    logic        mem_rdy [2];
    logic [2:0]  ack     [2];
    logic [2:0]  gnt     [2];
    logic [15:0] rd_data [2];
    logic        err     [2];
    logic        busy    [2];
    logic [25:1] mem_a   [2];
    logic        mem_rd  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Transaction-level reference state
    int          to_m [2] = '{8, 4};
    int          rr_m [2] = '{1, 0};
    int          ptr_m [2];
    bit          err_m [2];
    logic [15:0] rd_m  [2];
    logic [25:1] ma_m  [2];
    int          last_rise [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    stv_cart_mem_arbiter #(.RR_MODE(1), .TIMEOUT(8)) u_dut_rr (
        .clk_i(clk), .rst_i(rst), .res_n_i(res_n[0]), .req_i(req[0]),
        .a0_i(a[0][0]), .a1_i(a[0][1]), .a2_i(a[0][2]),
        .ack_o(ack[0]), .gnt_o(gnt[0]), .rd_data_o(rd_data[0]), .err_o(err[0]),
        .busy_o(busy[0]), .mem_a_o(mem_a[0]), .mem_rd_o(mem_rd[0]),
        .mem_di_i(mem_di[0]), .mem_rdy_i(mem_rdy[0])
    );

    stv_cart_mem_arbiter #(.RR_MODE(0), .TIMEOUT(4)) u_dut_fp (
        .clk_i(clk), .rst_i(rst), .res_n_i(res_n[1]), .req_i(req[1]),
        .a0_i(a[1][0]), .a1_i(a[1][1]), .a2_i(a[1][2]),
        .ack_o(ack[1]), .gnt_o(gnt[1]), .rd_data_o(rd_data[1]), .err_o(err[1]),
        .busy_o(busy[1]), .mem_a_o(mem_a[1]), .mem_rd_o(mem_rd[1]),
        .mem_di_i(mem_di[1]), .mem_rdy_i(mem_rdy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int d, input logic [2:0] r);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (rr_m[d] != 0) ? (ptr_m[d] + k) % 3 : k;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr_m[d] = 0; err_m[d] = 1'b0; rd_m[d] = '0; ma_m[d] = '0;
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_mem_rd", mem_rd[d], 0);
        chk("rst_mem_a", mem_a[d], 0);
        chk("rst_ack", ack[d], 0);
        chk("rst_gnt", gnt[d], 0);
        chk("rst_rd_data", rd_data[d], 0);
        chk("rst_err", err[d], 0);
        chk("rst_busy", busy[d], 0);
    endtask

    task automatic rand_addrs(input int d);
        for (int i = 0; i < 3; i++) a[d][i] = 25'($urandom);
    endtask

    // Called on an IDLE negedge with req[d] already set. Ends on the IDLE negedge after DONE.
    task automatic do_read(input int d, input logic [2:0] raise, input int delay,
                           input logic [15:0] data, input bit drop, output logic [2:0] g);
        int  w;
        bit  tout;
        w = pick(d, req[d]);
        @(negedge clk);
        g = gnt[d];
        last_rise[d] = cyc;
        chk("grant_gnt", gnt[d], 32'd1 << w);
        chk("grant_mem_rd", mem_rd[d], 1);
        chk("grant_mem_a", mem_a[d], a[d][w]);
        chk("grant_busy", busy[d], 1);
        chk("grant_ack", ack[d], 0);
        ma_m[d] = a[d][w];
        if (rr_m[d] != 0) ptr_m[d] = (w + 1) % 3;
        req[d] = req[d] | raise;
        for (int c = 0; c < 300; c++) begin
            mem_rdy[d] = (c == delay);
            mem_di[d]  = (c == delay) ? data : 16'($urandom);
            if (c == delay || c == to_m[d] - 1) break;
            @(negedge clk);
            chk("wait_mem_rd", mem_rd[d], 1);
            chk("wait_ack", ack[d], 0);
        end
        tout = (delay > to_m[d] - 1);
        @(negedge clk);
        mem_rdy[d] = 1'b0;
        if (tout) begin
            rd_m[d]  = 16'hFFFF;
            err_m[d] = 1'b1;
        end else begin
            rd_m[d] = data;
        end
        chk("done_ack", ack[d], 32'd1 << w);
        chk("done_mem_rd", mem_rd[d], 0);
        chk("done_gnt", gnt[d], 32'd1 << w);
        chk("done_rd_data", rd_data[d], rd_m[d]);
        chk("done_err", err[d], err_m[d]);
        chk("done_busy", busy[d], 1);
        if (drop) req[d][w] = 1'b0;
        @(negedge clk);
        chk("idle_ack", ack[d], 0);
        chk("idle_gnt", gnt[d], 0);
        chk("idle_busy", busy[d], 0);
        chk("idle_mem_rd", mem_rd[d], 0);
        chk("idle_rd_data", rd_data[d], rd_m[d]);
        chk("idle_mem_a", mem_a[d], ma_m[d]);
    endtask

    task automatic soft_reset(input int d);
        req[d]   = '0;
        res_n[d] = 1'b0;
        @(negedge clk);
        res_n[d]  = 1'b1;
        err_m[d]  = 1'b0;
        ptr_m[d]  = 0;
        chk("sres_mem_rd", mem_rd[d], 0);
        chk("sres_ack", ack[d], 0);
        chk("sres_gnt", gnt[d], 0);
        chk("sres_err", err[d], 0);
        chk("sres_busy", busy[d], 0);
        chk("sres_rd_data", rd_data[d], rd_m[d]);
        chk("sres_mem_a", mem_a[d], ma_m[d]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g;
        logic [2:0] rr_exp [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            res_n[d] = 1'b1; req[d] = '0; mem_rdy[d] = 1'b0; mem_di[d] = '0;
            rand_addrs(d);
        end
        model_reset();
        #12;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst = 1'b0;

        // Single read, MEM_RDY three cycles after MEM_RD rises
        a[0][0] = 25'h0123456;
        req[0]  = 3'b001;
        do_read(0, 3'b000, 3, 16'hBEEF, 1'b1, g);
        chk("single_gnt", g, 3'b001);
        chk("single_mem_a", mem_a[0], 25'h0123456);

        // Round-robin with all requests held
        soft_reset(0);
        req[0] = 3'b111;
        for (int i = 0; i < 4; i++) begin
            int prev;
            prev = last_rise[0];
            do_read(0, 3'b000, 0, 16'($urandom), 1'b0, g);
            chk("rr_order", g, rr_exp[i]);
            if (i > 0) chk("rr_spacing", last_rise[0] - prev, 3);
        end
        req[0] = '0;

        // Request withdrawn while console reset holds the arbiter off
        res_n[0] = 1'b0;
        req[0]   = 3'b001;
        @(negedge clk);
        req[0]   = '0;
        res_n[0] = 1'b1;
        ptr_m[0] = 0;
        @(negedge clk);
        chk("withdrawn_gnt", gnt[0], 0);
        chk("withdrawn_mem_rd", mem_rd[0], 0);

        // Timeout, sticky ERR, cleared by console reset
        req[0] = 3'b010;
        do_read(0, 3'b000, 1000, 16'h0000, 1'b1, g);
        chk("tout_err", err[0], 1);
        req[0] = 3'b100;
        do_read(0, 3'b000, 1, 16'h5A5A, 1'b1, g);
        chk("tout_err_sticky", err[0], 1);
        soft_reset(0);

        // Timeout tie: MEM_RDY in the last WAIT cycle wins
        req[1] = 3'b001;
        do_read(1, 3'b000, 3, 16'h1234, 1'b1, g);
        chk("tie_rd_data", rd_data[1], 16'h1234);
        chk("tie_err", err[1], 0);

        // Fixed priority with a late high-priority request
        req[1] = 3'b110;
        do_read(1, 3'b001, 0, 16'($urandom), 1'b1, g);
        chk("fp_first", g, 3'b010);
        do_read(1, 3'b000, 1, 16'($urandom), 1'b1, g);
        chk("fp_second", g, 3'b001);
        do_read(1, 3'b000, 2, 16'($urandom), 1'b1, g);
        chk("fp_third", g, 3'b100);
        req[1] = '0;

        // Console reset during WAIT; a late MEM_RDY must be ignored
        rand_addrs(0);
        req[0] = 3'b010;
        @(negedge clk);
        chk("mid_mem_rd", mem_rd[0], 1);
        ma_m[0]  = a[0][1];
        res_n[0] = 1'b0;
        req[0]   = '0;
        @(negedge clk);
        chk("mid_mem_rd_drop", mem_rd[0], 0);
        chk("mid_ack", ack[0], 0);
        chk("mid_gnt", gnt[0], 0);
        res_n[0]   = 1'b1;
        mem_rdy[0] = 1'b1;
        mem_di[0]  = 16'hDEAD;
        ptr_m[0]   = 0;
        err_m[0]   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("late_rdy_ack", ack[0], 0);
            chk("late_rdy_data", rd_data[0], rd_m[0]);
            chk("late_rdy_busy", busy[0], 0);
        end
        mem_rdy[0] = 1'b0;
        req[0] = 3'b111;
        do_read(0, 3'b000, 0, 16'($urandom), 1'b1, g);
        chk("ptr_cleared", g, 3'b001);
        req[0] = '0;

        // Randomized transactions on both instances
        for (int it = 0; it < 40; it++) begin
            int d;
            d = it % 2;
            if ($urandom_range(0, 5) == 0) soft_reset(d);
            rand_addrs(d);
            req[d] = 3'($urandom_range(1, 7));
            do_read(d, 3'($urandom_range(0, 7)), int'($urandom_range(0, to_m[d] + 2)),
                    16'($urandom), 1'b1, g);
            req[d] = '0;
        end

        // Asynchronous reset between clock edges, mid-transfer
        req[0] = 3'b100;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst    = 1'b0;
        req[0] = '0;
        model_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stv_cart_mem_arbiter.md
# stv_cart_mem_arbiter

Shares the single ST-V cartridge ROM port (MEM_A/MEM_RD/MEM_RDY/MEM_DI) among three read requesters:
- the A-bus direct-read path;
- the 315-5838 decompression chip;
- the 315-5881 decryption chip.

It sits between the cart requesters and the SDRAM/ROM channel. It arbitrates, sequences one read at a time, returns data and a one-cycle acknowledge to the winner, and aborts reads that never complete.

## Interface
Parameters:
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (0 > 1 > 2)
- TIMEOUT, 255, maximum WAIT cycles before abort (8-bit counter, legal 1..255)

Ports (index 0 = A-bus, 1 = 315-5838, 2 = 315-5881):
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- RES_N  in  1  synchronous soft reset, active-low (console reset)
- REQ  in  3  per-requester read request; level, held until its ACK
- A0  in  25 ([25:1])  read word address, requester 0
- A1  in  25 ([25:1])  read word address, requester 1
- A2  in  25 ([25:1])  read word address, requester 2
- ACK  out  3  one-hot, one-cycle completion pulse
- GNT  out  3  one-hot, owner of the current transfer; held WAIT through DONE
- RD_DATA  out  16  read data, valid while ACK is high and held until the next completion
- ERR  out  1  sticky timeout flag
- BUSY  out  1  high in WAIT and DONE
- MEM_A  out  25 ([25:1])  memory word address
- MEM_RD  out  1  memory read strobe; level, held until MEM_RDY
- MEM_DI  in  16  memory read data
- MEM_RDY  in  1  memory completion; data on MEM_DI is valid in the same cycle

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - If RES_N is high and any REQ bit is set, select a winner.
  - Register GNT, MEM_A = A[winner] and MEM_RD = 1, clear the timeout counter, and go to WAIT.
- Winner selection:
  - RR_MODE = 1: search starts at pointer P (reset value 0). After a grant to i, P = (i+1) mod 3.
  - RR_MODE = 0: lowest index wins and P is unused.
- WAIT (MEM_RDY high): MEM_RD = 0, RD_DATA = MEM_DI, ACK[gnt] = 1, go to DONE.
- WAIT (counter == TIMEOUT-1 and MEM_RDY low): MEM_RD = 0, RD_DATA = 16'hFFFF, ERR = 1, ACK[gnt] = 1, go to DONE.
- WAIT (otherwise): counter increments by 1 and does not wrap.
- DONE: ACK = 0, GNT = 0, go to IDLE. No arbitration happens in DONE, so the just-acknowledged requester has one cycle to drop REQ.
- REQ behaviour:
  - Sampled only in IDLE.
  - A REQ withdrawn before grant is never served.
  - Once a requester is granted, its REQ is ignored until DONE; the transfer completes and ACK still pulses.
- MEM_A is held stable from grant until the next grant.
- MEM_RDY seen outside WAIT is ignored.
- ERR is cleared only by RST or by RES_N low.
- RES_N low in any state takes effect at the next edge:
  - state = IDLE, MEM_RD = 0, ACK = 0, GNT = 0, ERR = 0, P = 0;
  - no ACK is issued for an aborted transfer;
  - RD_DATA and MEM_A are held.
- RST asserted: all registers are forced to reset values immediately, regardless of CLK.

## Timing
- Reset values: MEM_RD 0, MEM_A 0, ACK 0, GNT 0, RD_DATA 0, ERR 0, BUSY 0, state IDLE, P 0, counter 0.
- REQ seen high in IDLE at edge n: MEM_RD and GNT are high from cycle n+1.
- MEM_RDY high in cycle k: MEM_RD is low and ACK is high in cycle k+1.
- Minimum latency is REQ to ACK = 2 cycles, with MEM_RDY in the first WAIT cycle.
- Back-to-back issue: the next MEM_RD rises at k+3 (DONE at k+1, IDLE at k+2 samples REQ).
- Timeout: ACK in the TIMEOUT+1-th cycle after MEM_RD rises. If MEM_RDY arrives in the same cycle as the timeout, MEM_RDY wins: real data is returned and ERR is unchanged.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single read: REQ=3'b001, A0=25'h0123456, MEM_RDY asserted 3 cycles after MEM_RD with MEM_DI=16'hBEEF -> MEM_A=25'h0123456, then ACK=3'b001 for exactly one cycle with RD_DATA=16'hBEEF, ERR=0.
- Round-robin: REQ=3'b111 held, each read completed immediately -> GNT order 001, 010, 100, 001; MEM_RD issues 3 cycles apart.
- Fixed priority (RR_MODE=0): REQ=3'b110, then REQ[0] raised during the first transfer -> grants go to 2'b1 index 1, then index 0, then index 2.
- Timeout: TIMEOUT=8, MEM_RDY never asserted -> MEM_RD high 8 cycles, ACK pulses, RD_DATA=16'hFFFF, ERR=1 and stays 1; the next normal read leaves ERR=1; RES_N low clears it.
- Timeout tie: TIMEOUT=4, MEM_RDY in the 4th WAIT cycle with MEM_DI=16'h1234 -> RD_DATA=16'h1234, ERR=0.
- Reset mid-transfer:
  - RES_N low during WAIT -> MEM_RD=0 the next cycle, no ACK, P=0, and a later MEM_RDY is ignored.
  - RST asserted between clock edges -> outputs go to reset values immediately.
